// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the MSB-first SIPO receiver.
// Provides the default word width and the bit-counter width function.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 4;

    // Wide enough to count 0..width, which covers a frame with a parity bit.
    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_buf.sv
// One-word output holding register with valid/ready handshake and sticky overrun.
// Ports: clk, reset_n, load, din, perr_in, q_ready, ovr_clr -> q, q_perr, q_valid, overrun.
module sipo_hold_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             perr_in,
    input  logic             q_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_perr,
    output logic             q_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             perr_q, perr_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             blocked;

    assign accept  = valid_q & q_ready;
    assign blocked = valid_q & ~q_ready;

    always_comb begin
        q_d     = q_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        // A consumer accepting this cycle frees the slot for the new word.
        if (load && !blocked) begin
            q_d     = din;
            perr_d  = perr_in;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // A new drop beats a simultaneous clear.
        if (load && blocked) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q     <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign q       = q_q;
    assign q_perr  = perr_q;
    assign q_valid = valid_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// MSB-first serial-in parallel-out receiver with registered handshake output.
// Ports: clk, reset_n, sdi, sdi_en, sync, q_ready, ovr_clr -> q, q_valid, q_perr, overrun.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame.
module shift_reg_sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sdi,
    input  logic             sdi_en,
    input  logic             sync,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             q_perr,
    output logic             overrun,
    input  logic             ovr_clr
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam int SH_W  = WIDTH;
`else
    localparam int FRAME = WIDTH;
    // The oldest bit leaves the register exactly when the word completes,
    // so only WIDTH-1 bits ever need to be stored.
    localparam int SH_W  = WIDTH - 1;
`endif

    localparam int            CW   = sipo_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx;
    logic             last_bit;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             perr;

    // sync makes the bit on this edge frame bit 0.
    assign idx       = sync ? '0 : cnt_q;
    assign last_bit  = (idx == LAST);
    assign word_done = sdi_en & last_bit;

    always_comb begin
        cnt_d = cnt_q;
        if (sdi_en) begin
            cnt_d = last_bit ? '0 : idx + 1'b1;
        end else if (sync) begin
            cnt_d = '0;
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_q, par_d;

    assign word = sh_q;
    assign perr = par_q ^ sdi;

    always_comb begin
        sh_d  = sh_q;
        par_d = par_q;
        if (sdi_en) begin
            // The parity bit is checked, never stored.
            if (!last_bit) begin
                sh_d = {sh_q[WIDTH-2:0], sdi};
            end
            par_d = (idx == '0) ? sdi : (par_q ^ sdi);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    assign word = {sh_q, sdi};
    assign perr = 1'b0;

    always_comb begin
        sh_d = sh_q;
        if (sdi_en) begin
            sh_d = word[SH_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    sipo_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (word_done),
        .din    (word),
        .perr_in(perr),
        .q_ready(q_ready),
        .ovr_clr(ovr_clr),
        .q      (q),
        .q_perr (q_perr),
        .q_valid(q_valid),
        .overrun(overrun)
    );

endmodule

// File: doc/shift_reg_sipo_rx.md
# shift_reg_sipo_rx

Serial-in, parallel-out receiver: the receive end of our MSB-first serial word link, complementing the parallel-load serializer. It samples `sdi` on qualified clock edges, assembles WIDTH-bit words MSB-first, and presents each completed word on a registered parallel output. The output side uses a valid/ready handshake with a one-word holding register and a sticky overrun flag. It sits between the serial pin logic and the parallel datapath consumer.

## Interface
- `WIDTH`, default 4: data word width in bits; must be ≥ 2.
- `clk`  in  1: single clock; everything samples on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sdi`  in  1: serial data in; sampled only when `sdi_en`=1.
- `sdi_en`  in  1: the bit on `sdi` is valid this cycle.
- `sync`  in  1: word realignment; forces the current bit to be bit 0 of a new frame.
- `q`  out  WIDTH: received word; first bit received lands in `q[WIDTH-1]`.
- `q_valid`  out  1: `q` holds an unconsumed word.
- `q_ready`  in  1: consumer accepts `q` this cycle when `q_valid`=1.
- `q_perr`  out  1: parity error flag for the word on `q`; always 0 without parity support.
- `overrun`  out  1: sticky flag; a completed word was dropped.
- `ovr_clr`  in  1: synchronous clear of `overrun`.

## Operation
- Shift register `sh[WIDTH-1:0]`. On each edge with `sdi_en`=1 it updates as `sh <= {sh[WIDTH-2:0], sdi}`, so the data is MSB-first.
- Bit counter `cnt`:
  - Ranges 0..FRAME-1, where FRAME = WIDTH (or WIDTH+1 with parity).
  - Increments on `sdi_en`. At FRAME-1 with `sdi_en` it wraps to 0.
  - Holds when `sdi_en`=0.
- `sync`=1 with `sdi_en`=1: the bit is taken as frame bit 0, and `cnt` becomes 1.
- `sync`=1 with `sdi_en`=0: `cnt` becomes 0, and `sh` is unchanged.
- Frame completion happens on an edge with `sdi_en`=1 and an effective bit index of FRAME-1.
  - The completed word is `{sh[WIDTH-2:0], sdi}` when there is no parity bit, otherwise the current `sh`.
  - Delivery:
    - If `q_valid`=0, or `q_valid`=1 and `q_ready`=1: load `q`, set `q_perr` and `q_valid`=1.
    - If `q_valid`=1 and `q_ready`=0: drop the word, set `overrun`=1, and leave `q`, `q_perr` and `q_valid` unchanged.
- Handshake:
  - Acceptance happens when `q_valid` and `q_ready` are both 1 on an edge.
  - Acceptance without a simultaneous completion clears `q_valid`.
  - Acceptance with a simultaneous completion reloads the holding register, and `q_valid` stays 1.
  - `q` holds its value after acceptance; it is don't-care for consumers while `q_valid`=0.
- `overrun`: `ovr_clr` clears it. If a new overrun happens in the same cycle as `ovr_clr`, the set wins.
- Reset with `reset_n`=0, including in the middle of a frame: `sh`=0, `cnt`=0, `q`=0, `q_valid`=0, `q_perr`=0, `overrun`=0. The partial frame is discarded.

## Timing
- Latency: the last frame bit is sampled at edge k, and `q`/`q_valid` are updated by edge k, so they are visible in cycle k+1.
- Minimum frame time is FRAME cycles with `sdi_en` held high; back-to-back frames need no gap.
- A consumer with `q_ready` tied to 1 never sees an overrun.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SIPO_PARITY_EN`.
- Defined:
  - FRAME = WIDTH+1; the final bit is an even-parity bit.
  - `q_perr` = 1 when the XOR of the WIDTH data bits and the parity bit is 1.
  - `q_perr` is loaded together with `q`.
  - The parity bit is not shifted into `sh`.
- Undefined: FRAME = WIDTH, and `q_perr` is constant 0. The port stays present.

## Structure
- Package `sipo_pkg`:
  - `SIPO_DEFAULT_WIDTH` = 4.
  - Function `sipo_cnt_w(width)`, returning $clog2(width+1), for sizing `cnt`.
- Sub-module `sipo_hold_buf`:
  - Holding register with the valid/ready handshake and overrun logic.
  - Inputs: `load`, `din`, `perr_in`.
  - Outputs: `q`, `q_perr`, `q_valid`, `overrun`.
- Top level: shift register, bit counter and parity accumulator.

## Test plan
All scenarios use WIDTH = 4.
- Reset check: assert `reset_n`=0 mid-frame after 2 bits, release, then send 1,0,1,1 with `sdi_en`=1 → `q`=4'b1011, `q_valid`=1 one cycle after the 4th bit; no stale bits.
- Back-to-back words with `q_ready`=1: stream 1101 then 0110 continuously → `q`=4'hD then 4'h6 on consecutive frame boundaries; `overrun` stays 0.
- Gapped input: send 1001 with `sdi_en` toggling 1,0,1,0,… → `q`=4'h9; `cnt` holds during gaps; latency is measured from the last qualified bit.
- Overrun: `q_ready`=0, send 0011 then 1100 → `q`=4'h3 held, `overrun`=1. Then pulse `ovr_clr` together with `q_ready` → `overrun`=0, `q_valid`=0. Also check that `ovr_clr` in the same cycle as a new overrun leaves `overrun`=1.
- Realignment: send 2 bits, then `sync`=1 with `sdi_en`=1 and bits 1,1,1,0 → `q`=4'hE.
- Parity (`SIPO_PARITY_EN`): send 1010 with parity bit 0 → `q`=4'hA, `q_perr`=0. Send 1010 with parity bit 1 → `q_perr`=1. Confirm FRAME=5 timing.
